// File: rtl/mem_access_seq.sv
// mem_access_seq: multi-cycle sequencer between the CPU load/store path and a
// word-only data memory. Word accesses go straight through; sub-word loads
// select a lane and extend it; sub-word stores do a read-modify-write.
module mem_access_seq #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_uext,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } state_t;

    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_uext;
    logic [1:0]       req_lane;
    logic [31:0]      st_data;
    logic [31:0]      rd_word;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic bad_access;
    logic req_state;
    logic ack;
    logic expired;

    // Select the addressed lane of a read word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        uext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd1:    r = {{16{~uext & h[15]}}, h};
            2'd2:    r = {{24{~uext & b[7]}}, b};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overwrite the addressed lane of the read word with the store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (size)
            2'd1: begin
                if (lane[1]) r[31:16] = data[15:0];
                else         r[15:0]  = data[15:0];
            end
            2'd2:    r[{lane, 3'b000} +: 8] = data[7:0];
            default: r = data;
        endcase
        return r;
    endfunction

    assign accept     = (state == IDLE) && cpu_req;
    assign bad_access = (cpu_size == 2'd3)
                     || ((cpu_size == 2'd1) && cpu_addr[0])
                     || ((cpu_size == 2'd0) && (cpu_addr[1:0] != 2'b00));
    assign req_state  = (state == READ) || (state == WRITE);
    assign ack        = req_state && mem_ack;
    // An ack arriving in the expiry cycle takes priority over the timeout.
    assign expired    = req_state && !mem_ack && (TIMEOUT != 0) && (cnt == CNT_LAST);

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        state_next = state;
        cpu_busy   = (state != IDLE);
        cpu_done   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (bad_access)           state_next = RESP;
                    else if (!cpu_we)         state_next = READ;
                    else if (cpu_size == 2'd0) state_next = WRITE;
                    else                      state_next = READ;
                end
            end
            READ: begin
                mem_req = 1'b1;
                if (mem_ack)      state_next = req_we ? MERGE : RESP;
                else if (expired) state_next = RESP;
            end
            MERGE: state_next = WRITE;
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack || expired) state_next = RESP;
            end
            RESP: begin
                cpu_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, read data capture, lane merge and timeout counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we    <= 1'b0;
            req_size  <= '0;
            req_uext  <= 1'b0;
            req_lane  <= '0;
            st_data   <= '0;
            rd_word   <= '0;
            cnt       <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (accept) begin
                req_we    <= cpu_we;
                req_size  <= cpu_size;
                req_uext  <= cpu_uext;
                req_lane  <= cpu_addr[1:0];
                st_data   <= cpu_wdata;
                mem_addr  <= cpu_addr[ADDR_W-1:2];
                mem_wdata <= cpu_wdata;
                cpu_err   <= bad_access;
                cnt       <= '0;
            end
            if (ack) begin
                if (state == READ) begin
                    rd_word <= mem_rdata;
                    if (!req_we) cpu_rdata <= load_extend(mem_rdata, req_size, req_lane, req_uext);
                end
            end else if (req_state) begin
                cnt <= cnt + 1'b1;
                if (expired) cpu_err <= 1'b1;
            end
            if (state == MERGE) begin
                mem_wdata <= merge_lane(rd_word, st_data, req_size, req_lane);
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Testbench for mem_access_seq: table of single accesses against a memory
// model, a completion scoreboard, and hand sequences for reset, timeout and
// back-to-back corner cases.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic        cpu_uext = 1'b0;
    logic        cpu_busy;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_access_seq #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_uext(cpu_uext),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          reqs;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uext;
        logic [31:0] init;
        int          delay;
        logic [31:0] exp_rdata;
        logic        err;
        logic [31:0] exp_mem;
    } vec_t;

    localparam int NV = 19;

    exp_t        sbq[$];
    vec_t        vecs[NV];
    logic [31:0] mem[0:4095];
    int          ack_delay = 0;
    int          waited = 0;
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          req_cnt = 0;
    logic        prev_req = 1'b0;
    logic [29:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // Memory model: acks after ack_delay request cycles (negative = never).
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !mem_req) begin
                waited  = 0;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end else if (ack_delay >= 0 && waited == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[11:0]];
                if (mem_we) mem[mem_addr[11:0]] = mem_wdata;
                waited = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                waited++;
            end
        end
    end

    // Monitor: accept time, request cycles, bus stability, completion scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (cpu_req && !cpu_busy) begin
                acc_cyc = cyc;
                req_cnt = 0;
            end
            if (mem_req) begin
                req_cnt++;
                if (prev_req) begin
                    chk("bus_stable", {mem_addr, mem_we, 1'b0} ^ {h_addr, h_we, 1'b0}, '0);
                    chk("wdata_stable", mem_wdata, h_wdata);
                end
                h_addr  = mem_addr;
                h_wdata = mem_wdata;
                h_we    = mem_we;
            end
            prev_req = mem_req;
            if (cpu_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("err", cpu_err, e.err);
                    chk("latency", cyc - acc_cyc + 1, e.lat);
                    chk("req_cycles", req_cnt, e.reqs);
                    if (e.chk_rdata) chk("rdata", cpu_rdata, e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uext, input exp_t e);
        int n = 0;
        while (cpu_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("idle_wait", cpu_busy, 1'b0);
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_size  = size;
        cpu_uext  = uext;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   idx;
        int   n;

        //           we    addr         wdata         sz    uext  init          dly  exp_rdata     err   exp_mem
        vecs[0]  = '{1'b0, 32'h1003, 32'h0,        2'd2, 1'b0, 32'h80FF1234, 0,  32'hFFFFFF80, 1'b0, 32'h80FF1234};
        vecs[1]  = '{1'b0, 32'h1003, 32'h0,        2'd2, 1'b1, 32'h80FF1234, 0,  32'h00000080, 1'b0, 32'h80FF1234};
        vecs[2]  = '{1'b0, 32'h1002, 32'h0,        2'd1, 1'b1, 32'h80FF1234, 0,  32'h000080FF, 1'b0, 32'h80FF1234};
        vecs[3]  = '{1'b0, 32'h1002, 32'h0,        2'd1, 1'b0, 32'h80FF1234, 1,  32'hFFFF80FF, 1'b0, 32'h80FF1234};
        vecs[4]  = '{1'b0, 32'h1000, 32'h0,        2'd0, 1'b1, 32'h80FF1234, 2,  32'h80FF1234, 1'b0, 32'h80FF1234};
        vecs[5]  = '{1'b0, 32'h1001, 32'h0,        2'd2, 1'b0, 32'h80FF1234, 0,  32'h00000012, 1'b0, 32'h80FF1234};
        vecs[6]  = '{1'b0, 32'h1000, 32'h0,        2'd1, 1'b0, 32'h80FF1234, 0,  32'h00001234, 1'b0, 32'h80FF1234};
        vecs[7]  = '{1'b1, 32'h0101, 32'h000000AB, 2'd2, 1'b0, 32'h11223344, 0,  32'h0,        1'b0, 32'h1122AB44};
        vecs[8]  = '{1'b1, 32'h0102, 32'h0000BEEF, 2'd1, 1'b0, 32'h11223344, 1,  32'h0,        1'b0, 32'hBEEF3344};
        vecs[9]  = '{1'b1, 32'h0103, 32'hFFFFFF77, 2'd2, 1'b0, 32'h11223344, 0,  32'h0,        1'b0, 32'h77223344};
        vecs[10] = '{1'b1, 32'h0200, 32'hDEADBEEF, 2'd0, 1'b0, 32'h00000000, 0,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 32'h0103, 32'h0000BEEF, 2'd1, 1'b0, 32'h11223344, 0,  32'h0,        1'b1, 32'h11223344};
        vecs[12] = '{1'b0, 32'h0100, 32'h0,        2'd3, 1'b0, 32'h11223344, 0,  32'h0,        1'b1, 32'h11223344};
        vecs[13] = '{1'b0, 32'h0102, 32'h0,        2'd0, 1'b0, 32'h11223344, 0,  32'h0,        1'b1, 32'h11223344};
        vecs[14] = '{1'b1, 32'h0300, 32'h55555555, 2'd0, 1'b0, 32'hA5A5A5A5, -1, 32'h0,        1'b1, 32'hA5A5A5A5};
        vecs[15] = '{1'b0, 32'h0300, 32'h0,        2'd0, 1'b0, 32'hA5A5A5A5, -1, 32'h0,        1'b1, 32'hA5A5A5A5};
        vecs[16] = '{1'b1, 32'h0300, 32'h01020304, 2'd0, 1'b0, 32'hA5A5A5A5, 0,  32'h0,        1'b0, 32'h01020304};
        vecs[17] = '{1'b0, 32'h1002, 32'h0,        2'd2, 1'b1, 32'h80FF1234, 0,  32'h000000FF, 1'b0, 32'h80FF1234};
        vecs[18] = '{1'b1, 32'h0100, 32'h000000CD, 2'd2, 1'b0, 32'hFFFFFFFF, 3,  32'h0,        1'b0, 32'hFFFFFFCD};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", cpu_busy, 1'b0);
        chk("rst_done", cpu_done, 1'b0);
        chk("rst_rdata", cpu_rdata, '0);
        chk("rst_err", cpu_err, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single accesses
        for (int i = 0; i < NV; i++) begin
            idx = int'(vecs[i].addr[13:2]);
            mem[idx]  = vecs[i].init;
            ack_delay = vecs[i].delay;
            e.err       = vecs[i].err;
            e.rdata     = vecs[i].exp_rdata;
            e.chk_rdata = !vecs[i].we && !vecs[i].err;
            if (vecs[i].delay < 0) begin
                e.lat  = 6;
                e.reqs = 4;
            end else if (vecs[i].err) begin
                e.lat  = 2;
                e.reqs = 0;
            end else if (vecs[i].we && vecs[i].size != 2'd0) begin
                e.lat  = 5 + 2 * vecs[i].delay;
                e.reqs = 2 + 2 * vecs[i].delay;
            end else begin
                e.lat  = 3 + vecs[i].delay;
                e.reqs = 1 + vecs[i].delay;
            end
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uext, e);
            drain();
            chk($sformatf("mem_v%0d", i), mem[idx], vecs[i].exp_mem);
        end

        // Reset asserted mid-WRITE drops the request asynchronously
        ack_delay = -1;
        mem[32'h100] = 32'h0BADF00D;
        e = '{1'b0, 32'h0, 1'b0, 0, 0};
        issue(1'b1, 32'h0400, 32'h12121212, 2'd0, 1'b0, e);
        chk("req_in_write", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_busy", cpu_busy, 1'b0);
        chk("arst_done", cpu_done, 1'b0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_rdata", cpu_rdata, '0);
        chk("arst_err", cpu_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_mem", mem[32'h100], 32'h0BADF00D);
        ack_delay = 0;
        mem[32'h400] = 32'h80FF1234;
        e = '{1'b1, 32'h80FF1234, 1'b0, 3, 1};
        issue(1'b0, 32'h1000, 32'h0, 2'd0, 1'b0, e);
        drain();

        // Back-to-back word stores, second with a 3-cycle ack delay; a request
        // raised during RESP must be ignored
        mem[32'h140] = '0;
        mem[32'h141] = '0;
        mem[32'h180] = 32'h77777777;
        e = '{1'b0, 32'h0, 1'b0, 3, 1};
        issue(1'b1, 32'h0500, 32'hCAFEF00D, 2'd0, 1'b0, e);
        drain();
        chk("b2b_mem0", mem[32'h140], 32'hCAFEF00D);
        ack_delay = 3;
        e = '{1'b0, 32'h0, 1'b0, 6, 4};
        issue(1'b1, 32'h0504, 32'h12345678, 2'd0, 1'b0, e);
        n = 0;
        while (!cpu_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", cpu_done, 1'b1);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0600;
        cpu_wdata = 32'h99999999;
        cpu_size  = 2'd0;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        chk("resp_req_ignored", cpu_busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("resp_req_idle", cpu_busy, 1'b0);
        end
        chk("b2b_mem1", mem[32'h141], 32'h12345678);
        chk("resp_req_mem", mem[32'h180], 32'h77777777);
        chk("b2b_sb_empty", sbq.size(), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
